fft_output_serializer: RTL and testbench
========================================

Name: fft_output_serializer

Overview:
- Sits directly downstream of the final FFT stage (Stage_4). Captures each 16-point complex result frame, presented in parallel for one cycle.
- Reorders the frame from bit-reversed to natural order and streams it out one complex sample per cycle over a valid/ready interface.
- Two-deep ping-pong buffering absorbs back-pressure. Frames arriving with no free bank are dropped and flagged.

Parameters:
- N, 16, points per frame (power of two; 16 is the only verified value)
- W, 16, bits per real/imaginary component
- BIT_REVERSE, 1, 1 = output sample k is taken from input lane bitrev(k); 0 = output sample k is taken from lane k

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  single-cycle strobe; the frame on the in_* buses is valid this cycle
- in_real  input  N*W  packed real parts, lane i at [i*W +: W] (lane i = Stage_4 O_Xi_Real)
- in_im  input  N*W  packed imaginary parts, same lane layout
- out_valid  output  1  out_real, out_im, out_index and out_last are valid
- out_ready  input  1  downstream accepts the sample when out_valid && out_ready
- out_real  output  W  real part of the current sample
- out_im  output  W  imaginary part of the current sample
- out_index  output  log2(N)  natural-order bin number of the current sample (0..N-1)
- out_last  output  1  high with sample N-1 of a frame
- overflow  output  1  sticky; set when a frame is dropped, cleared only by rst

Behaviour:
- Reset (rst high at a clk edge):
  - Both banks empty; wr_sel=0, rd_sel=0, rd_idx=0.
  - out_valid=0, out_real=0, out_im=0, out_index=0, out_last=0, overflow=0.
  - rst takes priority over every other event, including mid-frame and mid-stream; any partially streamed frame is discarded.
- Bank state: full[0], full[1] flags. Write pointer wr_sel and read pointer rd_sel each toggle 0/1, so frames leave in arrival order.
- Release:
  - Asserted when out_valid && out_ready && rd_idx==N-1.
  - Effect: clear full[rd_sel], toggle rd_sel, set rd_idx to 0.
- Capture:
  - Occurs on any edge with in_valid && (!full[wr_sel] || (release && rd_sel==wr_sel)).
  - Effect: all N lanes of in_real/in_im are stored into bank wr_sel, full[wr_sel] is set, and wr_sel toggles.
  - A capture and a release of the same bank on one edge is legal. The bank ends full with the new frame.
- Drop: in_valid with no capture condition. The frame is discarded, overflow is set to 1, and bank state is unchanged.
- Output path:
  - Registered from bank rd_sel. out_valid = full[rd_sel], as seen after the edge.
  - Sample presented: lane bitrev(rd_idx), or lane rd_idx when BIT_REVERSE=0. out_index=rd_idx; out_last=(rd_idx==N-1).
  - Latency: a frame captured at edge t into an empty pipeline gives out_valid=1 with sample 0 in the cycle after edge t.
- Handshake:
  - rd_idx advances by 1 only on out_valid && out_ready.
  - While out_valid && !out_ready, all out_* signals hold stable.
  - out_valid never deasserts without a handshake, except on rst.
- Back-to-back throughput: with out_ready held at 1 and one frame every N cycles, the output is gap-free and no frames drop. The final sample of frame k is followed directly by sample 0 of frame k+1.
- Width rules:
  - No arithmetic on data; values pass through bit-exact, with no scaling or saturation.
  - rd_idx is log2(N) bits and wraps from N-1 to 0 only on release.
- in_valid on consecutive cycles is legal. Each asserted cycle is evaluated independently, so at most 2 frames are buffered.

Decomposition:
- Package fft_pkg:
  - constants FFT_N=16, FFT_W=16, FFT_LOG2N=4
  - typedef cplx_t {logic signed [W-1:0] re, im}
  - function bitrev(idx)
- Sub-module fft_frame_bank:
  - one N x 2W register bank with a capture-enable write of all lanes
  - combinational read mux by lane index
  - instantiated twice
- The top level holds the full flags, pointers, rd_idx control and output registers.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0 -> out_valid=0, out_real/out_im=0, overflow=0.
- Single frame, ramp data: lane i real=i, im=0x100+i, out_ready=1 -> 16 samples, out_real sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_index 0..15; out_last only on the 16th sample; first sample in the cycle after capture.
- Back-pressure: toggle out_ready every other cycle during the same frame -> identical sequence; outputs stable while out_ready=0; no duplicated or lost samples.
- Overflow: out_ready=0, send frames A, B, C on cycles 0, 1, 2 -> A and B buffered, C dropped, overflow=1 from cycle 3 onward. With out_ready=1, A then B stream out; overflow remains 1.
- Same-edge release and capture: both banks full, out_ready=1. The next frame arrives exactly on the edge of A's last handshake -> new frame is accepted, overflow stays 0, and output order is A, B, new.
- Reset mid-stream: assert rst while sample 5 of a frame is presented -> next cycle out_valid=0, both banks empty. A new frame then streams from out_index 0.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ==== fft_pkg : shared constants, sample type and bit-reversal helper ==== rev 1.0
package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_W     = 16;
  localparam int FFT_LOG2N = 4;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

  // Reverse the low nbits of idx; the fixed loop bound keeps it synthesizable.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
    int unsigned r;
    r = 0;
    for (int b = 0; b < 32; b++) begin
      if (b < int'(nbits)) r = {r[30:0], idx[b]};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_frame_bank.sv
`default_nettype none
// ==== fft_frame_bank : one N-lane complex frame store, parallel write, lane-indexed read ==== rev 1.0
module fft_frame_bank #(
  parameter int N = 16,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [N*W-1:0]       wr_real,
  input  logic [N*W-1:0]       wr_im,
  input  logic [$clog2(N)-1:0] rd_lane,
  output logic [W-1:0]         rd_real,
  output logic [W-1:0]         rd_im
);

  logic [W-1:0] mem_re [N];
  logic [W-1:0] mem_im [N];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < N; i++) begin
        mem_re[i] <= wr_real[i*W +: W];
        mem_im[i] <= wr_im[i*W +: W];
      end
    end
  end

  assign rd_real = mem_re[rd_lane];
  assign rd_im   = mem_im[rd_lane];

endmodule
`default_nettype wire

// File: rtl/fft_output_serializer.sv
`default_nettype none
// ==== fft_output_serializer : ping-pong capture of FFT frames, natural-order valid/ready stream ==== rev 1.0
module fft_output_serializer
  import fft_pkg::*;
#(
  parameter int N           = FFT_N,
  parameter int W           = FFT_W,
  parameter int BIT_REVERSE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [N*W-1:0]       in_real,
  input  logic [N*W-1:0]       in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_real,
  output logic [W-1:0]         out_im,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last,
  output logic                 overflow
);

  localparam int LOG2N = $clog2(N);

  logic [1:0]       full, full_n;
  logic             wr_sel, rd_sel, wr_sel_n, rd_sel_n;
  logic [LOG2N-1:0] rd_idx, rd_idx_n, lane;
  logic             hs, rel, cap;
  logic [W-1:0]     nxt_re, nxt_im;
  logic [W-1:0]     bank_re [2];
  logic [W-1:0]     bank_im [2];

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_frame_bank #(.N(N), .W(W)) u_bank (
        .clk     (clk),
        .we      (cap && (wr_sel == 1'(b))),
        .wr_real (in_real),
        .wr_im   (in_im),
        .rd_lane (lane),
        .rd_real (bank_re[b]),
        .rd_im   (bank_im[b])
      );
    end
  endgenerate

  always_comb begin
    hs  = out_valid && out_ready;
    rel = hs && (rd_idx == LOG2N'(N-1));
    cap = in_valid && (!full[wr_sel] || (rel && (rd_sel == wr_sel)));

    full_n = full;
    if (rel) full_n[rd_sel] = 1'b0;
    if (cap) full_n[wr_sel] = 1'b1;

    rd_sel_n = rd_sel ^ rel;
    wr_sel_n = wr_sel ^ cap;
    rd_idx_n = rel ? '0 : rd_idx + LOG2N'(hs);

    lane = (BIT_REVERSE != 0) ? LOG2N'(bitrev(32'(rd_idx_n), LOG2N)) : rd_idx_n;

    // A frame landing in the bank about to be read is forwarded straight from the inputs.
    if (cap && (wr_sel == rd_sel_n)) begin
      nxt_re = in_real[lane*W +: W];
      nxt_im = in_im[lane*W +: W];
    end else begin
      nxt_re = bank_re[rd_sel_n];
      nxt_im = bank_im[rd_sel_n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 2'b00;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_im    <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      full      <= full_n;
      wr_sel    <= wr_sel_n;
      rd_sel    <= rd_sel_n;
      rd_idx    <= rd_idx_n;
      out_valid <= full_n[rd_sel_n];
      out_real  <= nxt_re;
      out_im    <= nxt_im;
      out_index <= rd_idx_n;
      out_last  <= (rd_idx_n == LOG2N'(N-1));
      overflow  <= overflow | (in_valid && !cap);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_output_serializer.sv
`default_nettype none
// ==== tb_fft_output_serializer : frame-queue model plus directed scenarios ==== rev 1.0
module tb_fft_output_serializer;
  import fft_pkg::*;

  localparam int N = 16;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] in_real = '0;
  logic [N*W-1:0] in_im = '0;
  logic           out_valid, out_last, overflow;
  logic [W-1:0]   out_real, out_im;
  logic [3:0]     out_index;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_output_serializer #(.N(N), .W(W), .BIT_REVERSE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_real(in_real), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_im(out_im),
    .out_index(out_index), .out_last(out_last), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < 4; b++) if ((k & (1 << b)) != 0) r += (8 >> b);
    return r;
  endfunction

  // Model: FIFO of whole frames (max two) plus position in the head frame.
  logic [N*W-1:0] q_re[$];
  logic [N*W-1:0] q_im[$];
  int  pos = 0;
  bit  m_ovf = 1'b0;

  initial begin
    forever begin
      bit m_hs, m_rel;
      int cnt;
      @(posedge clk);
      if (rst) begin
        q_re.delete(); q_im.delete(); pos = 0; m_ovf = 1'b0;
      end else begin
        cnt   = q_re.size();
        m_hs  = (cnt > 0) && out_ready;
        m_rel = m_hs && (pos == N-1);
        if (m_rel) begin
          void'(q_re.pop_front()); void'(q_im.pop_front()); pos = 0;
        end else if (m_hs) begin
          pos++;
        end
        if (in_valid) begin
          if (cnt < 2 || m_rel) begin
            q_re.push_back(in_real); q_im.push_back(in_im);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  logic [W-1:0] log_re[$];
  int           log_idx[$];
  bit           log_last[$];

  initial begin
    forever begin
      logic [N*W-1:0] fr, fi;
      int k;
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(q_re.size() > 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (q_re.size() > 0) begin
        fr = q_re[0]; fi = q_im[0]; k = brev(pos);
        check("out_real", 32'(out_real), 32'(fr[k*W +: W]));
        check("out_im", 32'(out_im), 32'(fi[k*W +: W]));
        check("out_index", 32'(out_index), 32'(pos));
        check("out_last", 32'(out_last), 32'(pos == N-1));
      end
      if (out_valid && out_ready && !rst) begin
        log_re.push_back(out_real); log_idx.push_back(int'(out_index)); log_last.push_back(out_last);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] tag);
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_real[i*W +: W] = {tag, 8'(i)};
      in_im[i*W +: W]   = 16'h0100 + 16'(tag) * 16'h0200 + 16'(i);
    end
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_re.delete(); log_idx.delete(); log_last.delete();
  endtask

  task automatic check_ramp_log(input string tag);
    int exp_seq[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    check({tag, "_count"}, 32'(log_re.size()), 32'd16);
    for (int k = 0; k < 16 && k < log_re.size(); k++) begin
      check({tag, "_real"}, 32'(log_re[k]), 32'(exp_seq[k]));
      check({tag, "_index"}, 32'(log_idx[k]), 32'(k));
      check({tag, "_last"}, 32'(log_last[k]), 32'(k == 15));
    end
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_real", 32'(out_real), 32'd0);
    check("rst_im", 32'(out_im), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    step(1);
    rst = 1'b0;
    step(1);

    // Single ramp frame, always ready; sample 0 right after capture
    out_ready = 1'b1;
    clear_log();
    send(8'h00);
    @(negedge clk);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_im", 32'(out_im), 32'h100);
    step(20);
    check_ramp_log("ramp");

    // Same frame under alternating back-pressure
    out_ready = 1'b0;
    clear_log();
    send(8'h00);
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 2) == 1;
      step(1);
    end
    out_ready = 1'b1;
    step(2);
    check_ramp_log("bp");

    // Overflow: A and B buffered, C dropped
    rst = 1'b1; step(1); rst = 1'b0;
    out_ready = 1'b0;
    send(8'h01); send(8'h02); send(8'h03);
    @(negedge clk);
    check("ovf_set", 32'(overflow), 32'd1);
    step(1);
    clear_log();
    out_ready = 1'b1;
    step(40);
    check("ovf_count", 32'(log_re.size()), 32'd32);
    if (log_re.size() >= 32) begin
      check("ovf_a0", 32'(log_re[0]), 32'h0100);
      check("ovf_b0", 32'(log_re[16]), 32'h0200);
      check("ovf_b15", 32'(log_re[31]), 32'h020F);
    end
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Same-edge release of A and capture of D
    rst = 1'b1; step(1); rst = 1'b0;
    out_ready = 1'b0;
    send(8'h04); send(8'hC3);
    step(2);
    clear_log();
    out_ready = 1'b1;
    step(15);
    send(8'h05);
    step(40);
    check("same_count", 32'(log_re.size()), 32'd48);
    if (log_re.size() >= 48) begin
      check("same_a15", 32'(log_re[15]), 32'h040F);
      check("same_b0", 32'(log_re[16]), 32'hC300);
      check("same_d0", 32'(log_re[32]), 32'h0500);
      check("same_d1", 32'(log_re[33]), 32'h0508);
    end
    check("same_no_ovf", 32'(overflow), 32'd0);

    // Reset mid-stream while sample 5 is presented
    rst = 1'b1; step(1); rst = 1'b0;
    out_ready = 1'b1;
    send(8'h06);
    step(5);
    @(negedge clk);
    check("mid_index", 32'(out_index), 32'd5);
    check("mid_real", 32'(out_real), 32'h060A);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    step(1);
    clear_log();
    send(8'h07);
    step(20);
    check("mid_new_count", 32'(log_re.size()), 32'd16);
    if (log_re.size() >= 1) begin
      check("mid_new_idx0", 32'(log_idx[0]), 32'd0);
      check("mid_new_real0", 32'(log_re[0]), 32'h0700);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
